// File: rtl/pn_token_tx.sv
// Transmit end of the Polish Notation evaluator link: buffers tokens, sends a burst and collects results.
// Optional build macro PN_TX_REPLAY_EN keeps the loaded burst after DONE so a new start resends it.
module pn_token_tx #(
  parameter int BUFFER_LEN    = 16,
  parameter int CNT_W         = 5,
  parameter int RES_W         = 32,
  parameter int NUM_OF_RESULT = 4,
  parameter int TIMEOUT       = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             wr_op,
  input  logic [2:0]       wr_val,
  input  logic [1:0]       cfg_mode,
  input  logic             start,
  output logic             busy,
  output logic             full,
  output logic [CNT_W-1:0] tok_cnt,
  output logic [1:0]       pn_mode,
  output logic             pn_operator,
  output logic [2:0]       pn_in,
  output logic             pn_in_valid,
  input  logic             pn_out_valid,
  input  logic [RES_W-1:0] pn_out,
  output logic             res_valid,
  output logic [RES_W-1:0] res_data,
  output logic [1:0]       res_idx,
  output logic             done,
  output logic             timeout_err
);
  localparam int AW  = $clog2(BUFFER_LEN);
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int RCW = $clog2(NUM_OF_RESULT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_COLLECT, S_DONE} state_t;

  state_t           r_state;
  logic [3:0]       r_buf [BUFFER_LEN];
  logic [CNT_W-1:0] r_tok_cnt, r_ptr;
  logic [WCW-1:0]   r_wait_cnt;
  logic [RCW-1:0]   r_res_cnt;
  logic             r_full, r_busy, r_pn_op, r_pn_valid, r_res_valid, r_done, r_timeout_err;
  logic [2:0]       r_pn_in;
  logic [1:0]       r_pn_mode, r_res_idx;
  logic [RES_W-1:0] r_res_data;

  logic             w_fresh, w_start, w_wr;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [AW-1:0]    w_widx;

`ifdef PN_TX_REPLAY_EN
  // Set once a burst completes; the next write restarts the load at index 0.
  logic r_replay;
  always_ff @(posedge clk) begin
    if (rst)                            r_replay <= 1'b0;
    else if (w_wr)                      r_replay <= 1'b0;
    else if (r_state == S_DONE)         r_replay <= 1'b1;
  end
  assign w_fresh = r_replay;
`else
  assign w_fresh = 1'b0;
`endif

  assign w_start   = (r_state == S_IDLE) && start && (r_tok_cnt != '0);
  assign w_wr      = (r_state == S_IDLE) && wr_en && !w_start && (w_fresh || !r_full);
  assign w_cnt_nxt = w_fresh ? CNT_W'(1) : r_tok_cnt + 1'b1;
  assign w_widx    = w_fresh ? '0 : r_tok_cnt[AW-1:0];

  always_ff @(posedge clk) begin
    if (w_wr) r_buf[w_widx] <= {wr_op, wr_val};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_tok_cnt     <= '0;
      r_ptr         <= '0;
      r_wait_cnt    <= '0;
      r_res_cnt     <= '0;
      r_full        <= 1'b0;
      r_busy        <= 1'b0;
      r_pn_mode     <= '0;
      r_pn_op       <= 1'b0;
      r_pn_in       <= '0;
      r_pn_valid    <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_idx     <= '0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_pn_mode   <= '0;
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            // First token goes out on the cycle right after start.
            r_state              <= S_SEND;
            r_busy               <= 1'b1;
            r_timeout_err        <= 1'b0;
            r_pn_mode            <= cfg_mode;
            r_pn_valid           <= 1'b1;
            {r_pn_op, r_pn_in}   <= r_buf[0];
            r_ptr                <= CNT_W'(1);
          end else if (w_wr) begin
            r_tok_cnt <= w_cnt_nxt;
            r_full    <= (w_cnt_nxt == CNT_W'(BUFFER_LEN));
          end
        end
        S_SEND: begin
          if (r_ptr < r_tok_cnt) begin
            {r_pn_op, r_pn_in} <= r_buf[r_ptr[AW-1:0]];
            r_ptr              <= r_ptr + 1'b1;
          end else begin
            r_pn_valid <= 1'b0;
            r_pn_op    <= 1'b0;
            r_pn_in    <= '0;
            r_wait_cnt <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (pn_out_valid) begin
            r_res_valid <= 1'b1;
            r_res_data  <= pn_out;
            r_res_idx   <= '0;
            r_res_cnt   <= RCW'(1);
            r_state     <= S_COLLECT;
          end else if (r_wait_cnt == WCW'(TIMEOUT - 1)) begin
            r_timeout_err <= 1'b1;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_COLLECT: begin
          if (!pn_out_valid || r_res_cnt == RCW'(NUM_OF_RESULT)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_res_valid <= 1'b1;
            r_res_data  <= pn_out;
            r_res_idx   <= r_res_cnt[1:0];
            r_res_cnt   <= r_res_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ptr   <= '0;
`ifndef PN_TX_REPLAY_EN
          r_tok_cnt <= '0;
          r_full    <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign full        = r_full;
  assign tok_cnt     = r_tok_cnt;
  assign pn_mode     = r_pn_mode;
  assign pn_operator = r_pn_op;
  assign pn_in       = r_pn_in;
  assign pn_in_valid = r_pn_valid;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_idx     = r_res_idx;
  assign done        = r_done;
  assign timeout_err = r_timeout_err;
endmodule

// File: tb/tb_pn_token_tx.sv
// Bench for pn_token_tx: scenario table plus random bursts checked against a transaction-level model.
module tb_pn_token_tx;
  logic        clk = 1'b0;
  logic        rst, wr_en, wr_op, start, pn_out_valid;
  logic [2:0]  wr_val;
  logic [1:0]  cfg_mode;
  logic [31:0] pn_out;
  logic        busy, full, pn_operator, pn_in_valid, res_valid, done, timeout_err;
  logic [4:0]  tok_cnt;
  logic [1:0]  pn_mode, res_idx;
  logic [2:0]  pn_in;
  logic [31:0] res_data;

  int checks = 0;
  int failures = 0;

  pn_token_tx dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_op(wr_op), .wr_val(wr_val),
    .cfg_mode(cfg_mode), .start(start), .busy(busy), .full(full), .tok_cnt(tok_cnt),
    .pn_mode(pn_mode), .pn_operator(pn_operator), .pn_in(pn_in), .pn_in_valid(pn_in_valid),
    .pn_out_valid(pn_out_valid), .pn_out(pn_out), .res_valid(res_valid), .res_data(res_data),
    .res_idx(res_idx), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int         ntok;
    int         dly;
    int         nres;
    logic [1:0] mode;
    bit         collide;
    bit         fixed;
    int         exp_cnt;
    int         exp_nres;
    bit         exp_to;
  } vec_t;

  // One complete transaction: load, start, observe the burst, respond, compare.
  task automatic burst(input vec_t v, input string nm);
    logic [3:0]  exp_tok[$];
    logic [3:0]  got_tok[$];
    logic [31:0] exp_res[$];
    logic [31:0] got_res[$];
    int          got_idx[$];
    logic [3:0]  tk;
    logic [31:0] rv;
    int t, fall_t, done_t, last_res_t, sent, mode_first, mode_err, zero_err, cnt_at_done;
    bit  fell, seen_done, first;
    fell = 0; seen_done = 0; first = 1; sent = 0; mode_err = 0; zero_err = 0;
    fall_t = 0; done_t = 0; last_res_t = 0; mode_first = -1; cnt_at_done = -1;

    for (int i = 0; i < v.ntok; i++) begin
      tk = 4'($urandom);
      wr_en = 1'b1; {wr_op, wr_val} = tk;
      tick();
      if (exp_tok.size() < 16) exp_tok.push_back(tk);
    end
    wr_en = 1'b0;
    chk({nm, " tok_cnt"}, int'(tok_cnt), v.exp_cnt);
    chk({nm, " full"}, int'(full), int'(v.exp_cnt == 16));

    cfg_mode = v.mode; start = 1'b1;
    if (v.collide) begin wr_en = 1'b1; {wr_op, wr_val} = 4'($urandom); end
    tick();
    start = 1'b0; wr_en = 1'b0;
    chk({nm, " first_valid"}, int'(pn_in_valid), 1);
    chk({nm, " to_cleared"}, int'(timeout_err), 0);

    for (t = 0; t < 300; t++) begin
      if (pn_in_valid) begin
        got_tok.push_back({pn_operator, pn_in});
        if (first) mode_first = int'(pn_mode);
        else if (pn_mode != 2'd0) mode_err++;
        first = 0;
      end else if (pn_in != 3'd0 || pn_operator || pn_mode != 2'd0) begin
        zero_err++;
      end
      if (res_valid) begin
        got_res.push_back(res_data); got_idx.push_back(int'(res_idx)); last_res_t = t;
      end
      if (done) begin
        seen_done = 1; done_t = t; cnt_at_done = int'(tok_cnt);
        break;
      end
      if (!fell && !first && !pn_in_valid) begin fell = 1; fall_t = t; end
      if (fell && (t - fall_t) >= v.dly && sent < v.nres) begin
        rv = v.fixed ? ((sent == 0) ? 32'd7 : 32'hFFFF_FFFD) : $urandom;
        pn_out_valid = 1'b1; pn_out = rv;
        if (exp_res.size() < 4) exp_res.push_back(rv);
        sent++;
      end else begin
        pn_out_valid = 1'b0; pn_out = $urandom;
      end
      wr_en = 1'($urandom); start = ($urandom_range(0, 3) == 0);
      tick();
    end
    pn_out_valid = 1'b0; wr_en = 1'b0; start = 1'b0;

    chk({nm, " done_seen"}, int'(seen_done), 1);
    chk({nm, " tok_count"}, got_tok.size(), exp_tok.size());
    for (int i = 0; i < got_tok.size() && i < exp_tok.size(); i++)
      chk($sformatf("%s tok%0d", nm, i), int'(got_tok[i]), int'(exp_tok[i]));
    chk({nm, " mode_first"}, mode_first, int'(v.mode));
    chk({nm, " mode_later_zero"}, mode_err, 0);
    chk({nm, " idle_fields_zero"}, zero_err, 0);
    chk({nm, " tok_cnt_held"}, cnt_at_done, v.exp_cnt);
    chk({nm, " res_count"}, got_res.size(), v.exp_nres);
    for (int i = 0; i < got_res.size() && i < exp_res.size(); i++) begin
      chk($sformatf("%s res%0d", nm, i), int'(got_res[i]), int'(exp_res[i]));
      chk($sformatf("%s idx%0d", nm, i), got_idx[i], i);
    end
    chk({nm, " timeout_err"}, int'(timeout_err), int'(v.exp_to));
    if (v.exp_to) chk({nm, " wait_len"}, done_t - fall_t, 31);
    else          chk({nm, " done_after_res"}, done_t - last_res_t, 1);
    chk({nm, " busy_in_done"}, int'(busy), 1);

    tick();
    chk({nm, " done_pulse"}, int'(done), 0);
    chk({nm, " busy_after"}, int'(busy), 0);
`ifdef PN_TX_REPLAY_EN
    chk({nm, " tok_kept"}, int'(tok_cnt), v.exp_cnt);
`else
    chk({nm, " tok_cleared"}, int'(tok_cnt), 0);
`endif
    tick();
  endtask

  initial begin
    vec_t tbl[8];
    vec_t rv;
    tbl[0] = '{3,  0,  2, 2'd1, 1'b0, 1'b1, 3,  2, 1'b0};
    tbl[1] = '{17, 2,  1, 2'd2, 1'b0, 1'b0, 16, 1, 1'b0};
    tbl[2] = '{5,  40, 1, 2'd0, 1'b0, 1'b0, 5,  0, 1'b1};
    tbl[3] = '{1,  0,  6, 2'd3, 1'b0, 1'b0, 1,  4, 1'b0};
    tbl[4] = '{4,  30, 3, 2'd1, 1'b0, 1'b0, 4,  3, 1'b0};
    tbl[5] = '{2,  31, 2, 2'd2, 1'b0, 1'b0, 2,  0, 1'b1};
    tbl[6] = '{2,  1,  4, 2'd3, 1'b1, 1'b0, 2,  4, 1'b0};
    tbl[7] = '{16, 5,  0, 2'd1, 1'b0, 1'b0, 16, 0, 1'b1};

    rst = 1'b1; wr_en = 1'b0; wr_op = 1'b0; wr_val = '0; cfg_mode = '0;
    start = 1'b0; pn_out_valid = 1'b0; pn_out = '0;
    tick(); tick();
    chk("rst busy", int'(busy), 0);
    chk("rst tok_cnt", int'(tok_cnt), 0);
    chk("rst full", int'(full), 0);
    chk("rst pn_in_valid", int'(pn_in_valid), 0);
    chk("rst outs", int'({pn_mode, pn_operator, pn_in, res_valid, done, timeout_err, res_idx}), 0);
    chk("rst res_data", int'(res_data), 0);
    rst = 1'b0;
    tick();

    // Start with an empty buffer does nothing.
    start = 1'b1; tick(); start = 1'b0;
    chk("empty_start busy", int'(busy), 0);
    chk("empty_start valid", int'(pn_in_valid), 0);
    tick(); tick();
    chk("empty_start later", int'({busy, pn_in_valid, done}), 0);

    for (int i = 0; i < 8; i++) burst(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of SEND.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; {wr_op, wr_val} = 4'($urandom); tick();
    end
    wr_en = 1'b0; cfg_mode = 2'd2; start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("midrst sending", int'(pn_in_valid), 1);
    rst = 1'b1; tick();
    chk("midrst valid", int'(pn_in_valid), 0);
    chk("midrst tok_cnt", int'(tok_cnt), 0);
    chk("midrst busy", int'(busy), 0);
    rst = 1'b0; tick();
    chk("midrst idle", int'({busy, pn_in_valid, done}), 0);

    for (int n = 0; n < 20; n++) begin
      rv.ntok = $urandom_range(1, 20);
      rv.dly  = $urandom_range(0, 35);
      rv.nres = $urandom_range(0, 7);
      rv.mode = 2'($urandom);
      rv.collide = 1'($urandom);
      rv.fixed = 1'b0;
      rv.exp_cnt  = (rv.ntok > 16) ? 16 : rv.ntok;
      rv.exp_to   = !(rv.nres > 0 && rv.dly <= 30);
      rv.exp_nres = rv.exp_to ? 0 : ((rv.nres > 4) ? 4 : rv.nres);
      burst(rv, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
